// File: rtl/cmul_sched_pkg.sv
// Shared types and the round-robin search helper used by the complex-multiplier scheduler.
// The search runs over a fixed-width request vector so one function serves any requester count.
package cmul_sched_pkg;

    localparam int N_REQ_DEF        = 4;
    localparam int OPERAND_SIZE_DEF = 16;
    localparam int ID_W             = $clog2(N_REQ_DEF);
    localparam int RR_MAX           = 32;
    localparam int RR_IDX_W         = $clog2(RR_MAX);

    typedef struct packed {
        logic signed [OPERAND_SIZE_DEF-1:0] re;
        logic signed [OPERAND_SIZE_DEF-1:0] im;
    } cplx_t;

    typedef struct packed {
        logic                found;
        logic [RR_IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of valid[n-1:0], searching upward from ptr and wrapping at n.
    function automatic rr_pick_t rr_pick(input logic [RR_MAX-1:0]   valid,
                                         input logic [RR_IDX_W-1:0] ptr,
                                         input int unsigned         n);
        rr_pick_t            res;
        logic [31:0]         j;
        logic [RR_IDX_W-1:0] jj;
        res.found = 1'b0;
        res.idx   = {RR_IDX_W{1'b0}};
        for (int unsigned off = 0; off < RR_MAX; off++) begin
            j = 32'(ptr) + 32'(off);
            if (j >= 32'(n)) begin
                j = j - 32'(n);
            end else begin
                j = j;
            end
            jj = j[RR_IDX_W-1:0];
            if ((32'(off) < 32'(n)) && !res.found && valid[jj]) begin
                res.found = 1'b1;
                res.idx   = jj;
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/cmul_share_scheduler_cmul.sv
// Combinational fixed-point complex multiplier: four scaled real products, then re=ac-bd, im=ad+bc.
module complex_multiplier #(
    parameter int OS = 16,
    parameter int FS = 12,
    parameter int RW = 32
) (
    input  logic signed [OS-1:0] i_a_re,
    input  logic signed [OS-1:0] i_a_im,
    input  logic signed [OS-1:0] i_b_re,
    input  logic signed [OS-1:0] i_b_im,
    output logic signed [RW-1:0] o_re,
    output logic signed [RW-1:0] o_im
);

    localparam int PW = 2 * OS;
    localparam int XW = (RW > PW) ? RW : PW;

    // Full-precision product rescaled to FS fractional bits by arithmetic shift (truncation).
    function automatic logic signed [RW-1:0] fixed_multiply(input logic signed [OS-1:0] a,
                                                            input logic signed [OS-1:0] b);
        logic signed [PW-1:0] full;
        logic signed [XW-1:0] ext;
        full = PW'(a) * PW'(b);
        ext  = XW'(full >>> FS);
        return ext[RW-1:0];
    endfunction

    logic signed [RW-1:0] ac_s, bd_s, ad_s, bc_s;

    // Sum and difference wrap modulo 2^RW; nothing saturates here.
    always_comb begin
        ac_s = fixed_multiply(i_a_re, i_b_re);
        bd_s = fixed_multiply(i_a_im, i_b_im);
        ad_s = fixed_multiply(i_a_re, i_b_im);
        bc_s = fixed_multiply(i_a_im, i_b_re);
        o_re = ac_s - bd_s;
        o_im = ad_s + bc_s;
    end

endmodule

// File: rtl/cmul_share_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant to the first requester at or above i_ptr.
module rr_arbiter
    import cmul_sched_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_grant,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    rr_pick_t pick_s;

    // Search the request vector and expand the winner into index and one-hot forms.
    always_comb begin
        pick_s = rr_pick(RR_MAX'(i_req), RR_IDX_W'(i_ptr), N);
        o_any  = pick_s.found;
        o_idx  = pick_s.idx[IW-1:0];
        for (int k = 0; k < N; k++) begin
            o_grant[k] = pick_s.found && (pick_s.idx == RR_IDX_W'(k));
        end
    end

endmodule

// File: rtl/cmul_share_scheduler.sv
// Shares one complex multiplier among N_REQ valid/ready requesters with round-robin arbitration.
// The product lands in a single result register tagged with the owning requester's index.
module cmul_share_scheduler
    import cmul_sched_pkg::*;
#(
    parameter  int N_REQ           = 4,
    parameter  int operand_size    = 16,
    parameter  int fractional_size = 12,
    parameter  int expansion_size  = operand_size,
    localparam int RW              = operand_size + expansion_size,
    localparam int RID_W           = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [N_REQ-1:0]              i_req_valid,
    output logic [N_REQ-1:0]              o_req_ready,
    input  logic [N_REQ*operand_size-1:0] i_a_real,
    input  logic [N_REQ*operand_size-1:0] i_a_imag,
    input  logic [N_REQ*operand_size-1:0] i_b_real,
    input  logic [N_REQ*operand_size-1:0] i_b_imag,
    output logic                          o_res_valid,
    input  logic                          i_res_ready,
    output logic signed [RW-1:0]          o_res_real,
    output logic signed [RW-1:0]          o_res_imag,
    output logic [RID_W-1:0]              o_res_id
);

    logic [RID_W-1:0]               ptr_r;
    logic                           res_valid_r;
    logic signed [RW-1:0]           res_re_r;
    logic signed [RW-1:0]           res_im_r;
    logic [RID_W-1:0]               res_id_r;

    logic [N_REQ-1:0]               grant_s;
    logic [RID_W-1:0]               gidx_s;
    logic                           any_s;
    logic                           slot_free_s;
    logic                           xfer_s;
    logic signed [operand_size-1:0] a_re_s, a_im_s, b_re_s, b_im_s;
    logic signed [RW-1:0]           prod_re_s, prod_im_s;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_r),
        .o_grant (grant_s),
        .o_idx   (gidx_s),
        .o_any   (any_s)
    );

    // Slot frees when empty or being drained this cycle; ready is held low while in reset.
    always_comb begin
        slot_free_s = !res_valid_r || i_res_ready;
        xfer_s      = any_s && slot_free_s && !i_rst;
        o_req_ready = (slot_free_s && !i_rst) ? grant_s : {N_REQ{1'b0}};
    end

    // AND-OR operand mux driven by the one-hot grant.
    always_comb begin
        a_re_s = {operand_size{1'b0}};
        a_im_s = {operand_size{1'b0}};
        b_re_s = {operand_size{1'b0}};
        b_im_s = {operand_size{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            a_re_s = a_re_s | (grant_s[k] ? i_a_real[k*operand_size +: operand_size] : {operand_size{1'b0}});
            a_im_s = a_im_s | (grant_s[k] ? i_a_imag[k*operand_size +: operand_size] : {operand_size{1'b0}});
            b_re_s = b_re_s | (grant_s[k] ? i_b_real[k*operand_size +: operand_size] : {operand_size{1'b0}});
            b_im_s = b_im_s | (grant_s[k] ? i_b_imag[k*operand_size +: operand_size] : {operand_size{1'b0}});
        end
    end

    complex_multiplier #(
        .OS (operand_size),
        .FS (fractional_size),
        .RW (RW)
    ) u_cmul (
        .i_a_re (a_re_s),
        .i_a_im (a_im_s),
        .i_b_re (b_re_s),
        .i_b_im (b_im_s),
        .o_re   (prod_re_s),
        .o_im   (prod_im_s)
    );

    // Result register and pointer; the pointer only advances on an accepted transfer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ptr_r       <= {RID_W{1'b0}};
            res_valid_r <= 1'b0;
            res_re_r    <= {RW{1'b0}};
            res_im_r    <= {RW{1'b0}};
            res_id_r    <= {RID_W{1'b0}};
        end else if (xfer_s) begin
            res_valid_r <= 1'b1;
            res_re_r    <= prod_re_s;
            res_im_r    <= prod_im_s;
            res_id_r    <= gidx_s;
            ptr_r       <= (gidx_s == RID_W'(N_REQ - 1)) ? {RID_W{1'b0}} : gidx_s + RID_W'(1);
        end else if (i_res_ready) begin
            res_valid_r <= 1'b0;
        end else begin
            res_valid_r <= res_valid_r;
        end
    end

    assign o_res_valid = res_valid_r;
    assign o_res_real  = res_re_r;
    assign o_res_imag  = res_im_r;
    assign o_res_id    = res_id_r;

endmodule

// File: tb/tb_cmul_share_scheduler.sv
// Scoreboard bench: a behavioural arbiter/multiplier model queues expected results, a monitor pops them.
module tb_cmul_share_scheduler;

    localparam int N  = 4;
    localparam int OS = 16;
    localparam int FS = 12;
    localparam int RW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid, req_ready;
    logic [N*OS-1:0]   a_re, a_im, b_re, b_im;
    logic              res_valid, res_ready;
    logic signed [RW-1:0] res_re, res_im;
    logic [1:0]        res_id;

    typedef struct {
        int          id;
        logic [31:0] re;
        logic [31:0] im;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    bit   m_valid  = 1'b0;
    int   m_ptr    = 0;

    always #5 clk = ~clk;

    cmul_share_scheduler #(.N_REQ(N), .operand_size(OS), .fractional_size(FS)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_a_real    (a_re),
        .i_a_imag    (a_im),
        .i_b_real    (b_re),
        .i_b_imag    (b_im),
        .o_res_valid (res_valid),
        .i_res_ready (res_ready),
        .o_res_real  (res_re),
        .o_res_imag  (res_im),
        .o_res_id    (res_id)
    );

    task automatic check(input bit ok, input string name, input string got, input string want);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %s, expected %s", name, got, want);
    endtask

    function automatic longint opnd(input logic [N*OS-1:0] v, input int k);
        shortint s;
        s = v[k*OS +: OS];
        return longint'(s);
    endfunction

    function automatic longint fm(input longint x, input longint y);
        return (x * y) >>> FS;
    endfunction

    // Reference model: evaluate this cycle's grant from the spec rules and queue the product.
    task automatic step();
        logic [N-1:0] exp_ready;
        int           g;
        bit           free;
        longint       re, im;
        exp_t         e;
        #1;
        check(res_valid === m_valid, "res_valid", $sformatf("%b", res_valid), $sformatf("%b", m_valid));
        exp_ready = '0;
        g = -1;
        free = !m_valid || res_ready;
        if (!rst && free) begin
            for (int off = 0; off < N; off++) begin
                if (g < 0 && req_valid[(m_ptr + off) % N]) g = (m_ptr + off) % N;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        check(req_ready === exp_ready, "req_ready", $sformatf("%b", req_ready), $sformatf("%b", exp_ready));
        if (rst) begin
            m_valid = 1'b0;
            m_ptr   = 0;
            sb.delete();
        end else if (g >= 0) begin
            re = fm(opnd(a_re, g), opnd(b_re, g)) - fm(opnd(a_im, g), opnd(b_im, g));
            im = fm(opnd(a_re, g), opnd(b_im, g)) + fm(opnd(a_im, g), opnd(b_re, g));
            e.id = g;
            e.re = 32'(re);
            e.im = 32'(im);
            sb.push_back(e);
            m_valid = 1'b1;
            m_ptr   = (g + 1) % N;
        end else if (res_ready) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic rand_ops();
        for (int k = 0; k < N; k++) begin
            a_re[k*OS +: OS] = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
            a_im[k*OS +: OS] = ($urandom_range(7) == 0) ? 16'h8000 : 16'($urandom);
            b_re[k*OS +: OS] = 16'($urandom);
            b_im[k*OS +: OS] = 16'($urandom);
        end
    endtask

    // One clock: drive after the edge, then model/check before the falling edge.
    task automatic cycle(input logic [N-1:0] v, input bit r, input bit rs = 1'b0, input int k = -1,
                         input logic [15:0] ar = 16'h0, input logic [15:0] ai = 16'h0,
                         input logic [15:0] br = 16'h0, input logic [15:0] bi = 16'h0);
        @(posedge clk);
        #1;
        rst       = rs;
        req_valid = v;
        res_ready = r;
        if (k < 0) begin
            rand_ops();
        end else begin
            a_re[k*OS +: OS] = ar;
            a_im[k*OS +: OS] = ai;
            b_re[k*OS +: OS] = br;
            b_im[k*OS +: OS] = bi;
        end
        step();
    endtask

    // Monitor: every accepted result must match the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && res_valid && res_ready) begin
            check(sb.size() != 0, "sb_nonempty", "empty queue", "queued result");
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check(res_id === 2'(e.id) && res_re === e.re && res_im === e.im, "result",
                      $sformatf("id=%0d re=%h im=%h", res_id, res_re, res_im),
                      $sformatf("id=%0d re=%h im=%h", e.id, e.re, e.im));
            end
        end
    end

    initial begin
        rst = 1'b1; req_valid = '0; res_ready = 1'b0;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0;
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b1111, 1'b1, 1'b1);
        check(res_valid === 1'b0 && res_re === 32'sd0 && res_im === 32'sd0 && res_id === 2'd0,
              "reset_state", $sformatf("v=%b re=%h im=%h id=%0d", res_valid, res_re, res_im, res_id), "all zero");

        // single request: (1+1j)*(1-1j) = 2
        cycle(4'b0001, 1'b1, 1'b0, 0, 16'h1000, 16'h1000, 16'h1000, 16'hF000);
        cycle(4'b0000, 1'b1, 1'b0, 0, 16'h1000, 16'h1000, 16'h1000, 16'hF000);
        check(res_re === 32'sh0000_2000 && res_im === 32'sd0 && res_id === 2'd0, "single_req",
              $sformatf("re=%h im=%h id=%0d", res_re, res_im, res_id), "re=00002000 im=0 id=0");
        cycle(4'b0000, 1'b1);

        // all requesters streaming, no backpressure
        repeat (9) cycle(4'b1111, 1'b1);
        // backpressure then same-cycle drain and refill
        repeat (3) cycle(4'b1111, 1'b0);
        repeat (2) cycle(4'b1111, 1'b1);

        // fairness with req1/req3 from a fresh pointer
        cycle(4'b1010, 1'b1, 1'b1);
        repeat (5) cycle(4'b1010, 1'b1);

        // (-8)*(-8) = +64 without saturation
        cycle(4'b0000, 1'b1);
        cycle(4'b0100, 1'b1, 1'b0, 2, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
        cycle(4'b0000, 1'b1, 1'b0, 2, 16'h8000, 16'h0000, 16'h8000, 16'h0000);
        check(res_re === 32'sh0004_0000 && res_im === 32'sd0 && res_id === 2'd2, "wrap_neg8",
              $sformatf("re=%h im=%h id=%0d", res_re, res_im, res_id), "re=00040000 im=0 id=2");

        // reset with a held result and active requests
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0);
        cycle(4'b1111, 1'b0, 1'b1);
        cycle(4'b1100, 1'b1);
        cycle(4'b1100, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom), ($urandom_range(3) != 0));
        end

        repeat (3) cycle(4'b0000, 1'b1);
        check(sb.size() == 0, "drain", $sformatf("%0d pending", sb.size()), "0 pending");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
